sr_excitation_driver: RTL

//  Write-side driver for a bank of WIDTH srff flip-flops.
//  - Accepts a target word over a valid/ready handshake.
//  - Derives per-bit S/R excitation from the bank's current Q and pulses S/R for one cycle.
//  - Waits for the bank to settle, reads Q back and reports done and mismatch.
//  - Never drives S=R=1 (the srff forbidden input).
//  - Sits between control logic and an SR register bank in the same clock domain.

---
 rtl/sr_excitation_driver_if.sv | 27 ++
 rtl/sr_excitation_driver.sv | 114 +++++++++++
 2 files changed

// File: rtl/sr_excitation_driver_if.sv
// Target handshake and completion status between control logic and sr_excitation_driver.
// master = control side offering targets; slave = the driver.
interface sr_excitation_driver_if #(
  parameter int WIDTH = 8
);
  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;
  logic             done;
  logic             mismatch;

  modport master (
    output tgt_valid,
    output tgt_data,
    input  tgt_ready,
    input  done,
    input  mismatch
  );

  modport slave (
    input  tgt_valid,
    input  tgt_data,
    output tgt_ready,
    output done,
    output mismatch
  );
endinterface

// File: rtl/sr_excitation_driver.sv
// Purpose: drives S/R pulses into a WIDTH-bit srff bank to reach a target word; SR_DRIVER_RETRY_EN adds one retry on mismatch.
// Latency: accept edge -> done = 2+SETTLE_CYCLES cycles (2*(2+SETTLE_CYCLES) worst case with retry).
// Backpressure: tgt_ready only in IDLE; offers while busy are dropped, not queued.
module sr_excitation_driver #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sr_excitation_driver_if.slave tgt,
  input  logic [WIDTH-1:0]     q_fb,
  output logic [WIDTH-1:0]     s_out,
  output logic [WIDTH-1:0]     r_out
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tgt_q;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic             mismatch_q;
  logic             rb_diff;
`ifdef SR_DRIVER_RETRY_EN
  logic             retried;
`endif

  assign tgt.tgt_ready = (state == IDLE);
  assign tgt.done      = done_q;
  assign tgt.mismatch  = mismatch_q;
  assign rb_diff       = (q_fb != tgt_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tgt_q      <= '0;
      cnt        <= '0;
      s_out      <= '0;
      r_out      <= '0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
`ifdef SR_DRIVER_RETRY_EN
      retried    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (tgt.tgt_valid) begin
            tgt_q <= tgt.tgt_data;
            // Set only bits that must rise, reset only bits that must fall: S&R is never 1.
            s_out <= tgt.tgt_data & ~q_fb;
            r_out <= ~tgt.tgt_data & q_fb;
            state <= DRIVE;
`ifdef SR_DRIVER_RETRY_EN
            retried <= 1'b0;
`endif
          end
        end
        DRIVE: begin
          s_out <= '0;
          r_out <= '0;
          cnt   <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            state <= CHECK;
`ifdef SR_DRIVER_RETRY_EN
            // A first failing readback stays silent; CHECK then re-drives.
            if (rb_diff && !retried) begin
              done_q     <= 1'b0;
              mismatch_q <= 1'b0;
            end else begin
              done_q     <= 1'b1;
              mismatch_q <= rb_diff;
            end
`else
            done_q     <= 1'b1;
            mismatch_q <= rb_diff;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CHECK: begin
          done_q     <= 1'b0;
          mismatch_q <= 1'b0;
`ifdef SR_DRIVER_RETRY_EN
          if (!done_q) begin
            s_out   <= tgt_q & ~q_fb;
            r_out   <= ~tgt_q & q_fb;
            retried <= 1'b1;
            state   <= DRIVE;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
